// File: rtl/dm_ext.sv
// MEM-stage data memory: byte/half/word access, sign/zero-extended loads,
// address-error detection and a sticky first-fault latch for CP0.
module dm_ext #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter bit          LOG_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  memOp,
    input  logic [31:0] addr,
    input  logic [31:0] WData,
    input  logic [31:0] PC,
    input  logic        excClr,
    output logic [31:0] RData,
    output logic [3:0]  byteEn,
    output logic        AdEL,
    output logic        AdES,
    output logic        excValid,
    output logic [31:0] excPC,
    output logic [31:0] excAddr,
    output logic [4:0]  excCode
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem_q [DEPTH];

    logic [31:0]           offset;
    logic [ADDR_WIDTH-1:0] idx;
    logic [1:0]            lane;
    logic                  is_half;
    logic                  is_byte;
    logic                  sign_ext;
    logic                  misal;
    logic                  oor;
    logic                  fault;
    logic                  we;
    logic [31:0]           rword;
    logic [31:0]           wrep;
    logic [31:0]           wr_word_d;
    logic [15:0]           half_sel;
    logic [7:0]            byte_sel;

    logic        exc_valid_q, exc_valid_d;
    logic [31:0] exc_pc_q, exc_pc_d;
    logic [31:0] exc_addr_q, exc_addr_d;
    logic [4:0]  exc_code_q, exc_code_d;

    assign offset = addr - BASE_ADDR;
    assign idx    = offset[ADDR_WIDTH+1:2];
    assign lane   = offset[1:0];

    always_comb begin
        is_half  = 1'b0;
        is_byte  = 1'b0;
        sign_ext = 1'b0;
        unique case (memOp)
            3'b001: is_half = 1'b1;
            3'b010: begin
                is_half  = 1'b1;
                sign_ext = 1'b1;
            end
            3'b011: is_byte = 1'b1;
            3'b100: begin
                is_byte  = 1'b1;
                sign_ext = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        misal = 1'b0;
        if (is_half)
            misal = lane[0];
        else if (!is_byte)
            misal = |lane;
        oor   = |offset[31:ADDR_WIDTH+2];
        fault = misal | oor;
        AdES  = MemWrite & fault;
        AdEL  = MemRead & ~MemWrite & fault;
        we    = MemWrite & ~fault & ~reset;
    end

    always_comb begin
        byteEn = 4'b0000;
        if ((MemRead | MemWrite) && !fault) begin
            if (is_byte)
                byteEn = 4'b0001 << lane;
            else if (is_half)
                byteEn = lane[1] ? 4'b1100 : 4'b0011;
            else
                byteEn = 4'b1111;
        end
    end

    always_comb begin
        rword    = oor ? 32'h0 : mem_q[idx];
        half_sel = lane[1] ? rword[31:16] : rword[15:0];
        byte_sel = rword[{lane, 3'b000} +: 8];
        RData    = rword;
        if (is_half)
            RData = {{16{sign_ext & half_sel[15]}}, half_sel};
        else if (is_byte)
            RData = {{24{sign_ext & byte_sel[7]}}, byte_sel};
        if (AdEL || oor)
            RData = 32'h0;
    end

    // Narrow store data is replicated so each enabled lane sees its bytes.
    always_comb begin
        if (is_byte)
            wrep = {4{WData[7:0]}};
        else if (is_half)
            wrep = {2{WData[15:0]}};
        else
            wrep = WData;
        wr_word_d = rword;
        for (int k = 0; k < 4; k++)
            if (byteEn[k])
                wr_word_d[8*k +: 8] = wrep[8*k +: 8];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= 32'h0;
        end else if (we) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    always_comb begin
        exc_valid_d = exc_valid_q;
        exc_pc_d    = exc_pc_q;
        exc_addr_d  = exc_addr_q;
        exc_code_d  = exc_code_q;
        if ((AdEL || AdES) && (!exc_valid_q || excClr)) begin
            exc_valid_d = 1'b1;
            exc_pc_d    = PC;
            exc_addr_d  = addr;
            exc_code_d  = AdES ? 5'd5 : 5'd4;
        end else if (excClr) begin
            exc_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_valid_q <= 1'b0;
            exc_pc_q    <= 32'h0;
            exc_addr_q  <= 32'h0;
            exc_code_q  <= 5'd0;
        end else begin
            exc_valid_q <= exc_valid_d;
            exc_pc_q    <= exc_pc_d;
            exc_addr_q  <= exc_addr_d;
            exc_code_q  <= exc_code_d;
        end
    end

    assign excValid = exc_valid_q;
    assign excPC    = exc_pc_q;
    assign excAddr  = exc_addr_q;
    assign excCode  = exc_code_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (LOG_EN && we)
            $display("%d@%h: *%h <= %h", $time, PC, addr & ~32'd3, wr_word_d);
    end
`endif

endmodule

// File: tb/tb_dm_ext.sv
// Directed bench for dm_ext: two instances, base 0 and base 0x1000_0000.
module tb_dm_ext;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite, MemRead, excClr;
    logic [2:0]  memOp;
    logic [31:0] addr, WData, PC;

    logic [31:0] rd0, pc0, ea0, rd1, pc1, ea1;
    logic [3:0]  be0, be1;
    logic        el0, es0, ev0, el1, es1, ev1;
    logic [4:0]  ec0, ec1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dm_ext #(.ADDR_WIDTH(10), .BASE_ADDR(32'h0), .LOG_EN(1'b1)) u0 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .memOp(memOp), .addr(addr), .WData(WData), .PC(PC), .excClr(excClr),
        .RData(rd0), .byteEn(be0), .AdEL(el0), .AdES(es0),
        .excValid(ev0), .excPC(pc0), .excAddr(ea0), .excCode(ec0)
    );

    dm_ext #(.ADDR_WIDTH(10), .BASE_ADDR(32'h1000_0000), .LOG_EN(1'b1)) u1 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .memOp(memOp), .addr(addr), .WData(WData), .PC(PC), .excClr(excClr),
        .RData(rd1), .byteEn(be1), .AdEL(el1), .AdES(es1),
        .excValid(ev1), .excPC(pc1), .excAddr(ea1), .excCode(ec1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drv(input logic w, input logic r, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input logic clr);
        MemWrite = w;
        MemRead  = r;
        memOp    = op;
        addr     = a;
        WData    = d;
        PC       = pc;
        excClr   = clr;
        #1;
    endtask

    task automatic cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 3'b000, 32'h10, 32'h0, 32'h0, 0);
        cyc();
        reset = 1'b0;
        drv(0, 1, 3'b000, 32'h10, 32'h0, 32'h0, 0);
        chk("rst_rdata", rd0, 32'h0);
        chk("rst_ev", {31'b0, ev0}, 32'h0);
        chk("rst_ec", {27'b0, ec0}, 32'h0);
        chk("rst_ea", ea0, 32'h0);
        chk("rst_epc", pc0, 32'h0);
        chk("rst_adel", {31'b0, el0}, 32'h0);

        // word store/load
        drv(1, 0, 3'b000, 32'h10, 32'hDEADBEEF, 32'h40, 0);
        chk("sw_be", {28'b0, be0}, 32'hF);
        chk("sw_ades", {31'b0, es0}, 32'h0);
        cyc();
        drv(0, 1, 3'b000, 32'h10, 32'h0, 32'h44, 0);
        chk("lw_10", rd0, 32'hDEADBEEF);

        // narrow merge
        drv(1, 0, 3'b011, 32'h11, 32'h0000_00A5, 32'h48, 0);
        chk("sb_be", {28'b0, be0}, 32'h2);
        cyc();
        drv(1, 0, 3'b001, 32'h12, 32'hFFFF_1234, 32'h4C, 0);
        chk("sh_be", {28'b0, be0}, 32'hC);
        cyc();
        drv(0, 1, 3'b000, 32'h10, 32'h0, 32'h50, 0);
        chk("lw_merged", rd0, 32'h1234A5EF);
        drv(0, 1, 3'b100, 32'h11, 32'h0, 32'h50, 0);
        chk("lb_11", rd0, 32'hFFFFFFA5);
        chk("lb_be", {28'b0, be0}, 32'h2);
        drv(0, 1, 3'b011, 32'h11, 32'h0, 32'h50, 0);
        chk("lbu_11", rd0, 32'h000000A5);
        drv(0, 1, 3'b010, 32'h12, 32'h0, 32'h50, 0);
        chk("lh_12", rd0, 32'h00001234);
        drv(0, 1, 3'b010, 32'h10, 32'h0, 32'h50, 0);
        chk("lh_10", rd0, 32'hFFFFA5EF);
        drv(0, 1, 3'b001, 32'h10, 32'h0, 32'h50, 0);
        chk("lhu_10", rd0, 32'h0000A5EF);
        drv(0, 1, 3'b111, 32'h10, 32'h0, 32'h50, 0);
        chk("op7_word", rd0, 32'h1234A5EF);
        drv(0, 0, 3'b000, 32'h10, 32'h0, 32'h50, 0);
        chk("idle_be", {28'b0, be0}, 32'h0);
        chk("idle_rdata", rd0, 32'h1234A5EF);

        // misaligned store, MemRead also high: store wins
        drv(1, 1, 3'b000, 32'h13, 32'h0, 32'h100, 0);
        chk("mis_ades", {31'b0, es0}, 32'h1);
        chk("mis_adel", {31'b0, el0}, 32'h0);
        chk("mis_be", {28'b0, be0}, 32'h0);
        cyc();
        drv(0, 1, 3'b000, 32'h10, 32'h0, 32'h104, 0);
        chk("mis_unchanged", rd0, 32'h1234A5EF);
        chk("mis_ev", {31'b0, ev0}, 32'h1);
        chk("mis_ec", {27'b0, ec0}, 32'h5);
        chk("mis_ea", ea0, 32'h13);
        chk("mis_epc", pc0, 32'h100);

        drv(0, 1, 3'b010, 32'h21, 32'h0, 32'h108, 0);
        chk("lh21_adel", {31'b0, el0}, 32'h1);
        chk("lh21_rdata", rd0, 32'h0);
        cyc();
        chk("first_wins_ec", {27'b0, ec0}, 32'h5);
        chk("first_wins_ea", ea0, 32'h13);

        // clear and capture in the same cycle
        drv(0, 1, 3'b000, 32'h4001, 32'h0, 32'h10C, 1);
        chk("lw4001_adel", {31'b0, el0}, 32'h1);
        cyc();
        chk("clr_cap_ev", {31'b0, ev0}, 32'h1);
        chk("clr_cap_ec", {27'b0, ec0}, 32'h4);
        chk("clr_cap_ea", ea0, 32'h4001);
        chk("clr_cap_epc", pc0, 32'h10C);
        drv(0, 0, 3'b000, 32'h10, 32'h0, 32'h110, 1);
        cyc();
        chk("clr_ev", {31'b0, ev0}, 32'h0);
        chk("clr_hold_ec", {27'b0, ec0}, 32'h4);
        chk("clr_hold_ea", ea0, 32'h4001);

        // range boundary at 4*2^ADDR_WIDTH
        drv(0, 1, 3'b000, 32'hFFC, 32'h0, 32'h114, 0);
        chk("top_adel", {31'b0, el0}, 32'h0);
        chk("top_rdata", rd0, 32'h0);
        drv(0, 1, 3'b000, 32'h1000, 32'h0, 32'h118, 0);
        chk("oor_adel", {31'b0, el0}, 32'h1);
        cyc();
        chk("oor_ev", {31'b0, ev0}, 32'h1);

        // reset with a pending store
        reset = 1'b1;
        drv(1, 0, 3'b000, 32'h20, 32'h55, 32'h11C, 0);
        cyc();
        reset = 1'b0;
        drv(0, 1, 3'b000, 32'h20, 32'h0, 32'h120, 0);
        chk("rst_drop", rd0, 32'h0);
        drv(0, 1, 3'b000, 32'h10, 32'h0, 32'h120, 0);
        chk("rst_clr_10", rd0, 32'h0);
        chk("rst2_ev", {31'b0, ev0}, 32'h0);
        chk("rst2_ea", ea0, 32'h0);
        chk("rst2_ec", {27'b0, ec0}, 32'h0);
        chk("rst2_epc", pc0, 32'h0);

        // nonzero base address
        drv(1, 0, 3'b000, 32'h10000FFC, 32'hCAFEF00D, 32'h200, 0);
        chk("b_top_ades", {31'b0, es1}, 32'h0);
        chk("b_top_be", {28'b0, be1}, 32'hF);
        chk("b0_oor_ades", {31'b0, es0}, 32'h1);
        cyc();
        drv(0, 1, 3'b000, 32'h10000FFC, 32'h0, 32'h204, 0);
        chk("b_top_rd", rd1, 32'hCAFEF00D);
        drv(0, 1, 3'b000, 32'h10000000, 32'h0, 32'h204, 0);
        chk("b_w0_rd", rd1, 32'h0);
        drv(0, 1, 3'b000, 32'h10001000, 32'h0, 32'h204, 0);
        chk("b_hi_adel", {31'b0, el1}, 32'h1);
        drv(1, 0, 3'b000, 32'h0FFFFFFC, 32'h1, 32'h208, 0);
        chk("b_lo_ades", {31'b0, es1}, 32'h1);
        chk("b_lo_be", {28'b0, be1}, 32'h0);
        cyc();
        drv(0, 0, 3'b000, 32'h10000FFC, 32'h0, 32'h20C, 0);
        chk("b_lo_ev", {31'b0, ev1}, 32'h1);
        chk("b_lo_ec", {27'b0, ec1}, 32'h5);
        chk("b_lo_ea", ea1, 32'h0FFFFFFC);
        chk("b_top_keep", rd1, 32'hCAFEF00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
